fpu_addsub_param: RTL



---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_lzc.sv | 23 ++
 rtl/fpu_addsub_param.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the floating-point add/subtract core.
// Holds the FSM state encoding, status-word bit positions and op codes.
package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_ALIGN     = 3'd2,
    S_OPERATE   = 3'd3,
    S_NORMALIZE = 3'd4,
    S_ROUND     = 3'd5
  } fpu_state_t;

  localparam int ST_EXACT   = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_UNF     = 2;
  localparam int ST_INEXACT = 3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
  parameter int WIDTH = 26,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [CNT_W-1:0] lz_cnt
);

  logic found;

  always_comb begin
    lz_cnt = CNT_W'(WIDTH);
    found  = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && in_vec[i]) begin
        lz_cnt = CNT_W'(WIDTH - 1 - i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_param.sv
// Multi-cycle floating-point add/subtract with round-to-nearest-even.
// One operation walks DECODE->ALIGN->OPERATE->NORMALIZE->ROUND after start.
module fpu_addsub_param
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 10,
  parameter int MAN_W  = 21,
  parameter int DATA_W = 1 + EXP_W + MAN_W,
  parameter int BIAS   = 2**(EXP_W-1) - 1
) (
  input  logic              clock_100Khz,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] Op_A_in,
  input  logic [DATA_W-1:0] Op_B_in,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        status_out,
  output logic              busy,
  output logic              done
);

  localparam int DP_W  = MAN_W + 4;
  localparam int SUM_W = MAN_W + 5;
  localparam int LZ_W  = $clog2(MAN_W + 6);
  localparam logic signed [EXP_W+1:0] EXP_INF = (EXP_W+2)'(2 * BIAS + 1);
  localparam logic [EXP_W-1:0]        EXP_ONES = EXP_INF[EXP_W-1:0];
  localparam logic signed [EXP_W+1:0] EXP_ONE  = {{(EXP_W+1){1'b0}}, 1'b1};

  fpu_state_t state_q, state_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, data_q, data_d;
  logic              op_q, op_d, sa_q, sa_d, sb_q, sb_d;
  logic              inf_q, inf_d, nan_q, nan_d, zero_q, zero_d, done_q, done_d;
  logic [EXP_W-1:0]  ea_q, ea_d, eb_q, eb_d;
  logic [DP_W-1:0]   ma_q, ma_d, mb_q, mb_d, man_n_q, man_n_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic signed [EXP_W+1:0] exp_n_q, exp_n_d;
  logic [3:0]        status_q, status_d;

  logic [EXP_W-1:0]  exp_a, exp_b, diff;
  logic              swap, sticky, rnd_inc, inexact;
  logic [DP_W-1:0]   m_small, m_shift;
  logic [LZ_W-1:0]   lz;
  logic [SUM_W-1:0]  norm_shift;
  logic [MAN_W+1:0]  man_rnd;
  logic [MAN_W-1:0]  frac_f;
  logic signed [EXP_W+1:0] exp_f;

  fpu_lzc #(.WIDTH(SUM_W), .CNT_W(LZ_W)) u_lzc (
    .in_vec (sum_q),
    .lz_cnt (lz)
  );

  assign exp_a = opa_q[DATA_W-2:MAN_W];
  assign exp_b = opb_q[DATA_W-2:MAN_W];

  // Alignment: anything shifted below the round position is folded into sticky;
  // a shift of the full datapath width or more leaves only sticky.
  assign swap    = {eb_q, mb_q} > {ea_q, ma_q};
  assign diff    = swap ? (eb_q - ea_q) : (ea_q - eb_q);
  assign m_small = swap ? ma_q : mb_q;
  assign m_shift = m_small >> diff;
  assign sticky  = ((m_shift << diff) != m_small);

  // Carry results have lz == 0, so one shift covers both normalisation directions.
  assign norm_shift = sum_q << lz;

  assign rnd_inc = man_n_q[2] & (man_n_q[1] | man_n_q[0] | man_n_q[3]);
  assign inexact = man_n_q[2] | man_n_q[1] | man_n_q[0];
  assign man_rnd = {1'b0, man_n_q[DP_W-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
  assign exp_f   = exp_n_q + {{(EXP_W+1){1'b0}}, man_rnd[MAN_W+1]};
  assign frac_f  = man_rnd[MAN_W+1] ? man_rnd[MAN_W:1] : man_rnd[MAN_W-1:0];

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    inf_d    = inf_q;
    nan_d    = nan_q;
    sum_d    = sum_q;
    man_n_d  = man_n_q;
    exp_n_d  = exp_n_q;
    zero_d   = zero_q;
    data_d   = data_q;
    status_d = status_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DECODE;
          opa_d   = Op_A_in;
          opb_d   = Op_B_in;
          op_d    = op;
        end
      end
      S_DECODE: begin
        sa_d    = opa_q[DATA_W-1];
        sb_d    = opb_q[DATA_W-1] ^ (op_q == OP_SUB);
        ea_d    = exp_a;
        eb_d    = exp_b;
        ma_d    = (exp_a == '0) ? '0 : {1'b1, opa_q[MAN_W-1:0], 3'b000};
        mb_d    = (exp_b == '0) ? '0 : {1'b1, opb_q[MAN_W-1:0], 3'b000};
        inf_d   = (exp_a == EXP_ONES) | (exp_b == EXP_ONES);
        nan_d   = (exp_a == EXP_ONES) & (exp_b == EXP_ONES) & (sa_d != sb_d);
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
        if (swap) begin
          sa_d = sb_q;
          sb_d = sa_q;
          ea_d = eb_q;
          ma_d = mb_q;
        end
        mb_d    = {m_shift[DP_W-1:1], m_shift[0] | sticky};
        state_d = S_OPERATE;
      end
      S_OPERATE: begin
        sum_d   = (sa_q == sb_q) ? ({1'b0, ma_q} + {1'b0, mb_q})
                                 : ({1'b0, ma_q} - {1'b0, mb_q});
        state_d = S_NORMALIZE;
      end
      S_NORMALIZE: begin
        man_n_d = {norm_shift[SUM_W-1:2], norm_shift[1] | norm_shift[0]};
        exp_n_d = $signed({2'b00, ea_q}) + EXP_ONE
                - $signed({{(EXP_W+2-LZ_W){1'b0}}, lz});
        zero_d  = (sum_q == '0);
        state_d = S_ROUND;
      end
      S_ROUND: begin
        status_d = '0;
        if (nan_q) begin
          data_d           = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
          status_d[ST_OVF] = 1'b1;
        end else if (inf_q) begin
          data_d           = {sa_q, EXP_ONES, {MAN_W{1'b0}}};
          status_d[ST_OVF] = 1'b1;
        end else if (zero_q) begin
          data_d             = '0;
          status_d[ST_EXACT] = 1'b1;
        end else if (!exp_f[EXP_W+1] && (exp_f >= EXP_INF)) begin
          data_d               = {sa_q, EXP_ONES, {MAN_W{1'b0}}};
          status_d[ST_OVF]     = 1'b1;
          status_d[ST_INEXACT] = 1'b1;
        end else if (exp_f[EXP_W+1] || (exp_f == '0)) begin
          data_d               = {sa_q, {(DATA_W-1){1'b0}}};
          status_d[ST_UNF]     = 1'b1;
          status_d[ST_INEXACT] = 1'b1;
        end else begin
          data_d = {sa_q, exp_f[EXP_W-1:0], frac_f};
          if (inexact) status_d[ST_INEXACT] = 1'b1;
          else         status_d[ST_EXACT]   = 1'b1;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      inf_q    <= 1'b0;
      nan_q    <= 1'b0;
      sum_q    <= '0;
      man_n_q  <= '0;
      exp_n_q  <= '0;
      zero_q   <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      inf_q    <= inf_d;
      nan_q    <= nan_d;
      sum_q    <= sum_d;
      man_n_q  <= man_n_d;
      exp_n_q  <= exp_n_d;
      zero_q   <= zero_d;
      data_q   <= data_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  assign data_out   = data_q;
  assign status_out = status_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule
